// File: rtl/dram_rr_arbiter_if.sv
// Requester-side bundle: one access request channel plus its read-response channel.
interface dram_rr_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 2
);
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (output valid, we, addr, wdata, input ready, rsp_valid, rsp_rdata);
    modport slave  (input valid, we, addr, wdata, output ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/dram_rr_arbiter.sv
// Two-way round-robin arbiter for an async-read/sync-write RAM; DRAM_ARB_INIT_EN adds a FILL_VAL sweep after reset.
// Grant is combinational, read data returns one cycle after grant; held-off requesters stall, responses never backpressure.
module dram_rr_arbiter #(
    parameter int               ADDR_W   = 7,
    parameter int               DATA_W   = 2,
    parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    dram_rr_arbiter_if.slave  req0,
    dram_rr_arbiter_if.slave  req1,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [DATA_W-1:0] ram_d_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_o_i,
    output logic              init_done_o
);
    typedef enum logic {ST_INIT, ST_RUN} state_e;

`ifdef DRAM_ARB_INIT_EN
    localparam state_e RST_STATE = ST_INIT;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
`else
    localparam state_e RST_STATE = ST_RUN;
`endif

    state_e            state_q, state_d;
    logic              last_q, last_d;      // 1 = requester 1 was granted most recently
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              gnt0, gnt1;
    logic              rsp0_vld_q, rsp1_vld_q;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        ram_a_d     = ram_a_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        ram_a_o     = ram_a_q;
        ram_d_o     = '0;
        ram_we_o    = 1'b0;
        init_done_o = 1'b0;
`ifdef DRAM_ARB_INIT_EN
        sweep_d     = sweep_q;
`endif
        case (state_q)
            ST_INIT: begin
                ram_d_o = FILL_VAL;
`ifdef DRAM_ARB_INIT_EN
                ram_we_o = ~rst;
                ram_a_o  = sweep_q;
                ram_a_d  = sweep_q;
                sweep_d  = sweep_q + ADDR_W'(1);
                if (sweep_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            default: begin
                init_done_o = ~rst;
                if (!rst) begin
                    gnt0 = req0.valid & (~req1.valid | last_q);
                    gnt1 = req1.valid & ~gnt0;
                end
                if (gnt0) begin
                    ram_a_o  = req0.addr;
                    ram_d_o  = req0.wdata;
                    ram_we_o = req0.we;
                    ram_a_d  = req0.addr;
                    last_d   = 1'b0;
                end else if (gnt1) begin
                    ram_a_o  = req1.addr;
                    ram_d_o  = req1.wdata;
                    ram_we_o = req1.we;
                    ram_a_d  = req1.addr;
                    last_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RST_STATE;
            last_q       <= 1'b1;
            ram_a_q      <= '0;
            rsp0_vld_q   <= 1'b0;
            rsp1_vld_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifdef DRAM_ARB_INIT_EN
            sweep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            ram_a_q    <= ram_a_d;
            rsp0_vld_q <= gnt0 & ~req0.we;
            rsp1_vld_q <= gnt1 & ~req1.we;
            // async RAM output is valid for the granted address before this edge
            if (gnt0 && !req0.we) begin
                rsp0_rdata_q <= ram_o_i;
            end
            if (gnt1 && !req1.we) begin
                rsp1_rdata_q <= ram_o_i;
            end
`ifdef DRAM_ARB_INIT_EN
            sweep_q    <= sweep_d;
`endif
        end
    end

    assign req0.ready     = gnt0;
    assign req1.ready     = gnt1;
    assign req0.rsp_valid = rsp0_vld_q;
    assign req1.rsp_valid = rsp1_vld_q;
    assign req0.rsp_rdata = rsp0_rdata_q;
    assign req1.rsp_rdata = rsp1_rdata_q;
endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Bench for dram_rr_arbiter: RAM128X1S-like memory model plus a transaction-level arbiter/memory reference.
module tb_dram_rr_arbiter;
    localparam int AW = 7;
    localparam int DW = 2;
    localparam logic [DW-1:0] FILL = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) req0_if ();
    dram_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) req1_if ();

    logic [1:0]    drv_valid = 2'b00;
    logic          drv_we    [2];
    logic [AW-1:0] drv_addr  [2];
    logic [DW-1:0] drv_wdata [2];

    assign req0_if.valid = drv_valid[0];
    assign req0_if.we    = drv_we[0];
    assign req0_if.addr  = drv_addr[0];
    assign req0_if.wdata = drv_wdata[0];
    assign req1_if.valid = drv_valid[1];
    assign req1_if.we    = drv_we[1];
    assign req1_if.addr  = drv_addr[1];
    assign req1_if.wdata = drv_wdata[1];

    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d, ram_o;
    logic          ram_we, init_done;

    dram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FILL_VAL(FILL)) dut (
        .clk(clk), .rst(rst), .req0(req0_if), .req1(req1_if),
        .ram_a_o(ram_a), .ram_d_o(ram_d), .ram_we_o(ram_we),
        .ram_o_i(ram_o), .init_done_o(init_done)
    );

    // RAM primitive stand-in: lane 0 INIT = 128'b10, lane 1 INIT = 0
    logic [DW-1:0] ram [128];
    logic          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 128; i++) ram[i] <= (i == 1) ? 2'b01 : 2'b00;
            ram_loaded <= 1'b1;
        end else if (ram_we) begin
            ram[ram_a] <= ram_d;
        end
    end
    assign ram_o = ram[ram_a];

    int checks = 0;
    int errors = 0;

    // reference: who won last, memory image, pending responses, last driven address
    int            m_last;
    logic [DW-1:0] m_mem [128];
    logic          m_rv  [2];
    logic [DW-1:0] m_rd  [2];
    logic [AW-1:0] m_a;

    task automatic m_reset();
        m_last = 1;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = '0;   m_rd[1] = '0;
        m_a = '0;
    endtask

    function automatic int m_grant();
        if (drv_valid[0] && drv_valid[1]) return (m_last == 0) ? 1 : 0;
        if (drv_valid[0]) return 0;
        if (drv_valid[1]) return 1;
        return -1;
    endfunction

    task automatic m_commit(input int g);
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        if (g >= 0) begin
            m_last = g;
            m_a = drv_addr[g];
            if (drv_we[g]) m_mem[drv_addr[g]] = drv_wdata[g];
            else begin
                m_rv[g] = 1'b1;
                m_rd[g] = m_mem[drv_addr[g]];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv_valid = 2'b11;
        drv_we[0] = 1'b1; drv_addr[0] = 7'd5; drv_wdata[0] = 2'b11;
        drv_we[1] = 1'b1; drv_addr[1] = 7'd6; drv_wdata[1] = 2'b10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %0b want 0", ram_we); end
        checks++; if (req0_if.ready !== 1'b0 || req1_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b%0b want 00", req1_if.ready, req0_if.ready); end
        checks++; if (req0_if.rsp_valid !== 1'b0 || req1_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b%0b want 00", req1_if.rsp_valid, req0_if.rsp_valid); end
        checks++; if (req0_if.rsp_rdata !== 2'b00 || req1_if.rsp_rdata !== 2'b00) begin errors++; $display("FAIL reset_rsp_rdata: got %0h/%0h want 0/0", req0_if.rsp_rdata, req1_if.rsp_rdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %0b want 0", init_done); end
        drv_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
`ifndef DRAM_ARB_INIT_EN
        @(negedge clk);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL run_init_done: got %0b want 1", init_done); end
        checks++; if (ram_a !== 7'd0 || ram_we !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got a=%0h we=%0b want a=0 we=0", ram_a, ram_we); end
        m_commit(-1);
        @(posedge clk); #1;
`endif
    endtask

`ifdef DRAM_ARB_INIT_EN
    task automatic test_init_sweep();
        drv_valid = 2'b11;
        drv_we[0] = 1'b0; drv_addr[0] = 7'd3;
        drv_we[1] = 1'b0; drv_addr[1] = 7'd9;
        for (int i = 0; i <= 60; i++) begin
            @(negedge clk);
            checks++; if (ram_we !== 1'b1 || ram_a !== AW'(i) || ram_d !== FILL) begin errors++; $display("FAIL sweep1_%0d: got we=%0b a=%0h d=%0h want we=1 a=%0h d=%0h", i, ram_we, ram_a, ram_d, i, FILL); end
            checks++; if (init_done !== 1'b0 || req0_if.ready !== 1'b0 || req1_if.ready !== 1'b0) begin errors++; $display("FAIL sweep1_ctl_%0d: got done=%0b rdy=%0b%0b want 0 00", i, init_done, req1_if.ready, req0_if.ready); end
            if (i < 60) begin @(posedge clk); #1; end
        end
        rst = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL sweep_rst_we: got %0b want 0", ram_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            checks++; if (ram_we !== 1'b1 || ram_a !== AW'(i)) begin errors++; $display("FAIL sweep2_%0d: got we=%0b a=%0h want we=1 a=%0h", i, ram_we, ram_a, i); end
            checks++; if (init_done !== 1'b0 || req0_if.ready !== 1'b0 || req1_if.ready !== 1'b0) begin errors++; $display("FAIL sweep2_ctl_%0d: got done=%0b rdy=%0b%0b want 0 00", i, init_done, req1_if.ready, req0_if.ready); end
            @(posedge clk); #1;
        end
        drv_valid = 2'b00;
        @(negedge clk);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL sweep_done: got %0b want 1", init_done); end
        for (int i = 0; i < 128; i++) m_mem[i] = FILL;
        m_a = 7'd127;
        m_commit(-1);
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_alternate();
        drv_valid = 2'b11;
        drv_we[0] = 1'b0; drv_addr[0] = 7'd3;
        drv_we[1] = 1'b0; drv_addr[1] = 7'd9;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (req0_if.ready !== 1'(i % 2 == 0) || req1_if.ready !== 1'(i % 2 == 1)) begin errors++; $display("FAIL alt_ready_%0d: got %0b%0b want %0b%0b", i, req1_if.ready, req0_if.ready, i % 2 == 1, i % 2 == 0); end
            checks++; if (ram_a !== ((i % 2 == 0) ? 7'd3 : 7'd9) || ram_we !== 1'b0) begin errors++; $display("FAIL alt_ram_%0d: got a=%0h we=%0b", i, ram_a, ram_we); end
            checks++; if (req0_if.rsp_valid !== 1'(i % 2 == 1) || req1_if.rsp_valid !== 1'(i > 0 && i % 2 == 0)) begin errors++; $display("FAIL alt_rsp_%0d: got %0b%0b", i, req1_if.rsp_valid, req0_if.rsp_valid); end
            if (i % 2 == 1) begin
                checks++; if (req0_if.rsp_rdata !== m_mem[3]) begin errors++; $display("FAIL alt_rdata0_%0d: got %0h want %0h", i, req0_if.rsp_rdata, m_mem[3]); end
            end
            m_commit(m_grant());
            @(posedge clk); #1;
        end
        drv_valid = 2'b00;
        @(negedge clk);
        checks++; if (req1_if.rsp_valid !== 1'b1 || req0_if.rsp_valid !== 1'b0 || req1_if.rsp_rdata !== m_mem[9]) begin errors++; $display("FAIL alt_last_rsp: got v=%0b%0b d=%0h want v=10 d=%0h", req1_if.rsp_valid, req0_if.rsp_valid, req1_if.rsp_rdata, m_mem[9]); end
        m_commit(-1);
        @(posedge clk); #1;
    endtask

    task automatic test_first_read();
`ifdef DRAM_ARB_INIT_EN
        drv_addr[0] = 7'd5;
`else
        drv_addr[0] = 7'd1;
`endif
        drv_we[0] = 1'b0;
        drv_valid = 2'b01;
        @(negedge clk);
        checks++; if (req0_if.ready !== 1'b1 || ram_a !== drv_addr[0]) begin errors++; $display("FAIL first_read_grant: got rdy=%0b a=%0h", req0_if.ready, ram_a); end
        m_commit(m_grant());
        @(posedge clk); #1;
        drv_valid = 2'b00;
        @(negedge clk);
        checks++; if (req0_if.rsp_valid !== 1'b1 || req0_if.rsp_rdata !== 2'b01) begin errors++; $display("FAIL first_read_data: got v=%0b d=%0h want v=1 d=1", req0_if.rsp_valid, req0_if.rsp_rdata); end
        m_commit(-1);
        @(posedge clk); #1;
    endtask

    task automatic test_write_then_read();
        drv_valid = 2'b01;
        drv_we[0] = 1'b1; drv_addr[0] = 7'h7F; drv_wdata[0] = 2'b10;
        @(negedge clk);
        checks++; if (req0_if.ready !== 1'b1 || ram_we !== 1'b1 || ram_a !== 7'h7F || ram_d !== 2'b10) begin errors++; $display("FAIL wr_cycle: got rdy=%0b we=%0b a=%0h d=%0h want 1 1 7f 2", req0_if.ready, ram_we, ram_a, ram_d); end
        m_commit(m_grant());
        @(posedge clk); #1;
        drv_valid = 2'b10;
        drv_we[1] = 1'b0; drv_addr[1] = 7'h7F;
        @(negedge clk);
        checks++; if (req1_if.ready !== 1'b1 || ram_we !== 1'b0 || ram_a !== 7'h7F) begin errors++; $display("FAIL rd_cycle: got rdy=%0b we=%0b a=%0h want 1 0 7f", req1_if.ready, ram_we, ram_a); end
        checks++; if (req0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp: got %0b want 0", req0_if.rsp_valid); end
        m_commit(m_grant());
        @(posedge clk); #1;
        drv_valid = 2'b00;
        @(negedge clk);
        checks++; if (req1_if.rsp_valid !== 1'b1 || req1_if.rsp_rdata !== 2'b10) begin errors++; $display("FAIL wr_rd_data: got v=%0b d=%0h want v=1 d=2", req1_if.rsp_valid, req1_if.rsp_rdata); end
        checks++; if (ram_we !== 1'b0 || ram_a !== 7'h7F) begin errors++; $display("FAIL idle_hold: got we=%0b a=%0h want 0 7f", ram_we, ram_a); end
        m_commit(-1);
        @(posedge clk); #1;
    endtask

    task automatic test_single_req1();
        drv_valid = 2'b10;
        drv_we[1] = 1'b0; drv_addr[1] = 7'd20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (req1_if.ready !== 1'b1 || req0_if.ready !== 1'b0) begin errors++; $display("FAIL solo1_%0d: got %0b%0b want 10", i, req1_if.ready, req0_if.ready); end
            m_commit(m_grant());
            @(posedge clk); #1;
        end
        drv_valid = 2'b11;
        drv_we[0] = 1'b0; drv_addr[0] = 7'd21;
        @(negedge clk);
        checks++; if (req0_if.ready !== 1'b1 || req1_if.ready !== 1'b0) begin errors++; $display("FAIL join0: got %0b%0b want 01", req1_if.ready, req0_if.ready); end
        m_commit(m_grant());
        @(posedge clk); #1;
        drv_valid = 2'b10;
        @(negedge clk);
        checks++; if (req1_if.ready !== 1'b1 || req0_if.ready !== 1'b0) begin errors++; $display("FAIL join1: got %0b%0b want 10", req1_if.ready, req0_if.ready); end
        m_commit(m_grant());
        @(posedge clk); #1;
        drv_valid = 2'b00;
        @(negedge clk);
        m_commit(-1);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int g_prev = -1;
        for (int c = 0; c < 400; c++) begin
            int g;
            for (int n = 0; n < 2; n++) begin
                // a held-off requester keeps its request stable
                if (!(drv_valid[n] && g_prev != n)) begin
                    drv_valid[n] = ($urandom_range(0, 3) != 0);
                    drv_we[n]    = 1'($urandom_range(0, 1));
                    drv_addr[n]  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
                    drv_wdata[n] = DW'($urandom_range(0, 3));
                end
            end
            @(negedge clk);
            g = m_grant();
            checks++; if (req0_if.ready !== 1'(g == 0) || req1_if.ready !== 1'(g == 1)) begin errors++; $display("FAIL rnd_ready_%0d: got %0b%0b want grant %0d", c, req1_if.ready, req0_if.ready, g); end
            checks++; if (ram_we !== ((g >= 0) ? drv_we[g] : 1'b0) || ram_a !== ((g >= 0) ? drv_addr[g] : m_a)) begin errors++; $display("FAIL rnd_ram_%0d: got we=%0b a=%0h grant %0d", c, ram_we, ram_a, g); end
            if (g >= 0 && drv_we[g]) begin
                checks++; if (ram_d !== drv_wdata[g]) begin errors++; $display("FAIL rnd_wdata_%0d: got %0h want %0h", c, ram_d, drv_wdata[g]); end
            end
            checks++; if (req0_if.rsp_valid !== m_rv[0] || req0_if.rsp_rdata !== m_rd[0]) begin errors++; $display("FAIL rnd_rsp0_%0d: got v=%0b d=%0h want v=%0b d=%0h", c, req0_if.rsp_valid, req0_if.rsp_rdata, m_rv[0], m_rd[0]); end
            checks++; if (req1_if.rsp_valid !== m_rv[1] || req1_if.rsp_rdata !== m_rd[1]) begin errors++; $display("FAIL rnd_rsp1_%0d: got v=%0b d=%0h want v=%0b d=%0h", c, req1_if.rsp_valid, req1_if.rsp_rdata, m_rv[1], m_rd[1]); end
            m_commit(g);
            g_prev = g;
            @(posedge clk); #1;
        end
        drv_valid = 2'b00;
    endtask

    task automatic test_async_reset();
        drv_valid = 2'b01;
        drv_we[0] = 1'b1; drv_addr[0] = 7'd2; drv_wdata[0] = 2'b11;
        @(posedge clk); #1;
        drv_we[0] = 1'b0;
        @(posedge clk); #1;
        drv_we[0] = 1'b1;
        checks++; if (req0_if.rsp_valid !== 1'b1 || req0_if.rsp_rdata !== 2'b11) begin errors++; $display("FAIL pre_rst_rsp: got v=%0b d=%0h want v=1 d=3", req0_if.rsp_valid, req0_if.rsp_rdata); end
        rst = 1'b1;
        #1;
        checks++; if (req0_if.rsp_valid !== 1'b0 || req0_if.rsp_rdata !== 2'b00) begin errors++; $display("FAIL async_rst_rsp: got v=%0b d=%0h want v=0 d=0", req0_if.rsp_valid, req0_if.rsp_rdata); end
        checks++; if (ram_we !== 1'b0 || req0_if.ready !== 1'b0) begin errors++; $display("FAIL async_rst_we: got we=%0b rdy=%0b want 0 0", ram_we, req0_if.ready); end
        @(posedge clk); #1;
        drv_valid = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_mem[i] = (i == 1) ? 2'b01 : 2'b00;
        drv_we[0] = 1'b0; drv_addr[0] = '0; drv_wdata[0] = '0;
        drv_we[1] = 1'b0; drv_addr[1] = '0; drv_wdata[1] = '0;
        m_reset();
        test_reset();
`ifdef DRAM_ARB_INIT_EN
        test_init_sweep();
`endif
        test_alternate();
        test_first_read();
        test_write_then_read();
        test_single_req1();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
